// File: rtl/esa_pkg.sv
// -----------------------------------------------------------------------------
// esa_pkg
// Shared types and helpers for the equal-segmentation approximate adder.
//   nseg()          number of equal segments for a WIDTH/SEG_W split
//   esa_seg_t       per-segment partial result {sum, g, p}
//   ESA_MODE_*      encoding of the exact_i mode bit
// The segment sum field is sized for the widest supported segment. Narrower
// segments zero-fill the upper bits, and they are truncated again at use.
// -----------------------------------------------------------------------------
package esa_pkg;

   localparam int   ESA_SEG_W_MAX   = 32;
   localparam logic ESA_MODE_APPROX = 1'b0;
   localparam logic ESA_MODE_EXACT  = 1'b1;

   function automatic int nseg(input int width, input int seg_w);
      return width / seg_w;
   endfunction

   typedef struct packed {
      logic [ESA_SEG_W_MAX-1:0] sum;  // segment sum without carry-in, zero-filled above SEG_W
      logic                     g;    // segment generates a carry
      logic                     p;    // segment propagates an incoming carry (sum all ones)
   } esa_seg_t;

endpackage

// File: rtl/esa_seg_add.sv
// -----------------------------------------------------------------------------
// esa_seg_add
// Combinational SEG_W-bit segment adder with carry-in tied to zero.
// It produces the segment sum plus the generate and propagate terms that the
// carry-lookahead correction stage uses.
// Ports:
//   i_a, i_b   in   SEG_W        segment operands
//   o_seg      out  esa_seg_t    {sum, g, p}
// -----------------------------------------------------------------------------
module esa_seg_add
   import esa_pkg::*;
#(
   parameter int SEG_W = 4
) (
   input  logic [SEG_W-1:0] i_a,
   input  logic [SEG_W-1:0] i_b,
   output esa_seg_t         o_seg
);

   logic [SEG_W:0] w_full;

   assign w_full    = {1'b0, i_a} + {1'b0, i_b};
   assign o_seg.sum = ESA_SEG_W_MAX'(w_full[SEG_W-1:0]);
   assign o_seg.g   = w_full[SEG_W];
   assign o_seg.p   = &w_full[SEG_W-1:0];

endmodule

// File: rtl/esa_adder_pipe.sv
// -----------------------------------------------------------------------------
// esa_adder_pipe
// Two-stage, valid/ready pipelined equal-segmentation approximate adder.
// S1 registers the per-segment {sum, g, p}. S2 either drops the inter-segment
// carries (approximate) or restores them with a carry-lookahead (exact).
// Optional build macro: ESA_ERR_CNT_EN. When it is defined, the error flag and
// the saturating error counter are built. When it is undefined, err_o and
// err_cnt_o are tied to 0 and err_clr_i is ignored.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    operand handshake
//   add1_i, add2_i, exact_i    operands and mode (1 = exact)
//   out_valid_o / out_ready_i  result handshake
//   result_o                   WIDTH+1-bit sum including carry-out
//   err_o                      approximate beat differs from exact sum
//   err_cnt_o, err_clr_i       saturating error-beat counter and its clear
// -----------------------------------------------------------------------------
module esa_adder_pipe
   import esa_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int SEG_W     = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     add1_i,
   input  logic [WIDTH-1:0]     add2_i,
   input  logic                 exact_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [WIDTH:0]       result_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   input  logic                 err_clr_i
);

   localparam int NSEG = nseg(WIDTH, SEG_W);

   if (SEG_W < 1 || SEG_W > ESA_SEG_W_MAX || WIDTH < SEG_W || (WIDTH % SEG_W) != 0)
   begin : g_param_check
      $error("esa_adder_pipe: WIDTH must be a non-zero multiple of SEG_W (SEG_W <= %0d)",
             ESA_SEG_W_MAX);
   end

   // ---------------- handshake ----------------
   logic w_s2_adv, w_s1_adv, w_accept;
   logic r_s1_full, r_s2_full;

   // in_ready_o depends combinationally on out_ready_i. This lets a full
   // pipeline accept a new beat in the same cycle that it drains one.
   assign w_s2_adv   = !r_s2_full | out_ready_i;
   assign w_s1_adv   = !r_s1_full | w_s2_adv;
   assign w_accept   = in_valid_i & w_s1_adv;
   assign in_ready_o = w_s1_adv;

   // ---------------- stage 1: segment adders ----------------
   esa_seg_t w_seg [NSEG];
   esa_seg_t r_seg [NSEG];
   logic     r_s1_exact;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      esa_seg_add #(.SEG_W(SEG_W)) u_seg_add (
         .i_a   (add1_i[k*SEG_W +: SEG_W]),
         .i_b   (add2_i[k*SEG_W +: SEG_W]),
         .o_seg (w_seg[k])
      );
   end

   // NOTE: sequential state always uses non-blocking assignments, so every
   // register samples pre-edge values regardless of block order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_full <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_full <= w_accept;
      end
   end

   // NOTE: payload registers are not reset. The stage-full flag qualifies
   // them, so clearing them would only add reset fan-out.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_seg      <= w_seg;
         r_s1_exact <= exact_i;
      end
   end

   // ---------------- stage 2: carry lookahead / correction ----------------
   logic [NSEG-1:0] w_cin;
   logic [WIDTH:0]  w_res;
   logic [WIDTH:0]  r_result;

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_cin = '0;
      for (int k = 1; k < NSEG; k++) begin
         w_cin[k] = r_seg[k-1].g | (r_seg[k-1].p & w_cin[k-1]);
      end
   end

   always_comb begin
      w_res = '0;
      for (int k = 0; k < NSEG; k++) begin
         if (r_s1_exact == ESA_MODE_EXACT) begin
            w_res[k*SEG_W +: SEG_W] = SEG_W'(r_seg[k].sum + ESA_SEG_W_MAX'(w_cin[k]));
         end else begin
            w_res[k*SEG_W +: SEG_W] = SEG_W'(r_seg[k].sum);
         end
      end
      if (r_s1_exact == ESA_MODE_EXACT) begin
         w_res[WIDTH] = r_seg[NSEG-1].g | (r_seg[NSEG-1].p & w_cin[NSEG-1]);
      end else begin
         w_res[WIDTH] = r_seg[NSEG-1].g;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s2_full <= 1'b0;
         r_result  <= '0;
      end else if (w_s2_adv) begin
         r_s2_full <= r_s1_full;
         if (r_s1_full) begin
            r_result <= w_res;
         end
      end
   end

   assign out_valid_o = r_s2_full;
   assign result_o    = r_result;

   // ---------------- error flag and counter ----------------
`ifdef ESA_ERR_CNT_EN
   logic                 w_err;
   logic                 w_consume;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // An approximate result is wrong exactly when some dropped inter-segment
   // carry would have been 1. A single segment has no such carries.
   if (NSEG > 1) begin : g_err
      assign w_err = (r_s1_exact == ESA_MODE_APPROX) & (|w_cin[NSEG-1:1]);
   end else begin : g_no_err
      assign w_err = 1'b0;
   end

   assign w_consume = r_s2_full & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if (w_s2_adv && r_s1_full) begin
         r_err <= w_err;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || err_clr_i) begin
         r_err_cnt <= '0;
      end else if (w_consume && r_err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign err_o     = r_err;
   assign err_cnt_o = r_err_cnt;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr = err_clr_i;
   assign err_o            = 1'b0;
   assign err_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_esa_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_esa_adder_pipe
// Directed self-checking bench for esa_adder_pipe.
// The main instance uses WIDTH=16, SEG_W=4 and ERR_CNT_W=16. A second
// instance with ERR_CNT_W=4 exercises counter saturation and clear priority.
// Error expectations collapse to 0 when ESA_ERR_CNT_EN is not defined.
// -----------------------------------------------------------------------------
module tb_esa_adder_pipe;

`ifdef ESA_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   // main instance
   logic        in_valid, in_ready, exact, out_valid, out_ready, err, err_clr;
   logic [15:0] add1, add2;
   logic [16:0] result;
   logic [15:0] err_cnt;

   // narrow-counter instance
   logic        in_valid4, in_ready4, exact4, out_valid4, out_ready4, err4, err_clr4;
   logic [15:0] add1_4, add2_4;
   logic [16:0] result4;
   logic [3:0]  err_cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   esa_adder_pipe #(.WIDTH(16), .SEG_W(4), .ERR_CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .add1_i(add1), .add2_i(add2), .exact_i(exact),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .result_o(result), .err_o(err), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
   );

   esa_adder_pipe #(.WIDTH(16), .SEG_W(4), .ERR_CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid4), .in_ready_o(in_ready4),
      .add1_i(add1_4), .add2_i(add2_4), .exact_i(exact4),
      .out_valid_o(out_valid4), .out_ready_i(out_ready4),
      .result_o(result4), .err_o(err4), .err_cnt_o(err_cnt4), .err_clr_i(err_clr4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat through an otherwise idle pipeline with out_ready held high.
   task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ex, input logic [16:0] exp_res, input logic exp_err);
      add1 = a; add2 = b; exact = ex; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_res"}, 32'(result), 32'(exp_res));
      check({tag, "_err"}, 32'(err), 32'(exp_err & ERR_EN));
   endtask

   // One erroring beat into dut4, optionally clearing in its consume cycle.
   task automatic send4_clr(input string tag, input logic clr, input logic [3:0] exp_cnt);
      add1_4 = 16'h000F; add2_4 = 16'h0001; exact4 = 1'b0; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      tick();
      check({tag, "_vld"}, 32'(out_valid4), 32'd1);
      err_clr4 = clr;
      tick();
      err_clr4 = 1'b0;
      check({tag, "_cnt"}, 32'(err_cnt4), 32'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; add1 = '0; add2 = '0; exact = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
      in_valid4 = 1'b0; add1_4 = '0; add2_4 = '0; exact4 = 1'b0; out_ready4 = 1'b1; err_clr4 = 1'b0;
      repeat (2) tick();

      // reset state
      check("rst_valid",  32'(out_valid), 32'd0);
      check("rst_result", 32'(result),    32'd0);
      check("rst_err",    32'(err),       32'd0);
      check("rst_cnt",    32'(err_cnt),   32'd0);
      rst = 1'b0;
      #1;
      check("rst_ready",  32'(in_ready),  32'd1);

      // directed vectors, both modes
      send_one("c0f_apx", 16'h000F, 16'h0001, 1'b0, 17'h00000, 1'b1);
      send_one("c0f_ex",  16'h000F, 16'h0001, 1'b1, 17'h00010, 1'b0);
      send_one("cff_apx", 16'hFFFF, 16'hFFFF, 1'b0, 17'h1EEEE, 1'b1);
      send_one("cff_ex",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE, 1'b0);
      send_one("c12_apx", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
      send_one("c12_ex",  16'h1234, 16'h4321, 1'b1, 17'h05555, 1'b0);
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("cnt_after_vec", 32'(err_cnt), ERR_EN ? 32'd2 : 32'd0);

      // stall: three back-to-back beats, downstream not ready
      out_ready = 1'b0; exact = 1'b1;
      add1 = 16'h0001; add2 = 16'h0002; in_valid = 1'b1;
      #1 check("stall_rdy_a", 32'(in_ready), 32'd1);
      tick();
      add1 = 16'h00FF; add2 = 16'h0001;
      #1 check("stall_rdy_b", 32'(in_ready), 32'd1);
      tick();
      add1 = 16'h8000; add2 = 16'h8000;
      #1 check("stall_rdy_c", 32'(in_ready), 32'd0);
      check("stall_vld",   32'(out_valid), 32'd1);
      check("stall_res_a", 32'(result), 32'h00003);
      repeat (2) tick();
      check("stall_hold_a", 32'(result), 32'h00003);
      check("stall_hold_rdy", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1 check("release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("order_b", 32'(result), 32'h00100);
      check("order_b_vld", 32'(out_valid), 32'd1);
      tick();
      check("order_c", 32'(result), 32'h10000);
      check("order_c_vld", 32'(out_valid), 32'd1);
      tick();
      check("order_empty", 32'(out_valid), 32'd0);
      check("cnt_after_stall", 32'(err_cnt), ERR_EN ? 32'd2 : 32'd0);

      // reset with two erroring beats in flight
      out_ready = 1'b0;
      add1 = 16'h000F; add2 = 16'h0001; exact = 1'b0; in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      check("fly_vld", 32'(out_valid), 32'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_vld",   32'(out_valid), 32'd0);
      check("mid_rst_cnt",   32'(err_cnt),   32'd0);
      check("mid_rst_ready", 32'(in_ready),  32'd1);
      rst = 1'b0; out_ready = 1'b1;
      tick();
      check("post_rst_vld", 32'(out_valid), 32'd0);

      // narrow counter: 17 erroring beats back-to-back saturate at 15
      add1_4 = 16'h000F; add2_4 = 16'h0001; exact4 = 1'b0; in_valid4 = 1'b1;
      repeat (17) tick();
      in_valid4 = 1'b0;
      check("sat_stream_vld", 32'(out_valid4), 32'd1);
      repeat (3) tick();
      check("sat_cnt", 32'(err_cnt4), ERR_EN ? 32'd15 : 32'd0);
      check("sat_empty", 32'(out_valid4), 32'd0);

      // clear wins over a concurrent increment
      send4_clr("clr_sat", 1'b1, 4'd0);
      send4_clr("inc_one", 1'b0, ERR_EN ? 4'd1 : 4'd0);
      send4_clr("clr_one", 1'b1, 4'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
